// File: rtl/ifu_decode_stage.sv
// Instruction fetch + decode front end: one outstanding fetch at a time, decodes addi,
// stops on ebreak or any unsupported encoding, and presents fields to EX via valid/ready.
module ifu_decode_stage #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            wen,
  output logic [XLEN-1:0] immI,
  output logic [XLEN-1:0] pc_o,
  output logic            halt,
  output logic            illegal,
  output logic [1:0]      state_dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid (imem_req / id_valid) and
  // ready (imem_ready / id_ready) are both high; valid never drops before that transfer.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} state_t;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [4:0]      rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic            wen_q, wen_d;
  logic            halt_q, halt_d;
  logic            illegal_q, illegal_d;
  logic            is_addi, is_ebreak;

  assign is_addi   = (imem_rdata[6:0] == 7'b0010011) && (imem_rdata[14:12] == 3'b000);
  assign is_ebreak = (imem_rdata == EBREAK);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_out_d  = pc_out_q;
    imm_d     = imm_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    wen_d     = wen_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    case (state_q)
      S_REQ: begin
        // A response in this state cannot belong to us, so rvalid is not looked at here.
        if (imem_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          rd_d     = imem_rdata[11:7];
          rs1_d    = imem_rdata[19:15];
          rs2_d    = imem_rdata[24:20];
          imm_d    = {{(XLEN-12){imem_rdata[31]}}, imem_rdata[31:20]};
          pc_out_d = pc_q;
          if (is_addi) begin
            wen_d   = (imem_rdata[11:7] != 5'd0);
            state_d = S_OUT;
          end else begin
            wen_d     = 1'b0;
            halt_d    = 1'b1;
            illegal_d = illegal_q | ~is_ebreak;
            state_d   = S_HALT;
          end
        end
      end
      S_OUT: begin
        if (id_ready) begin
          pc_d    = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
          state_d = S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      pc_out_q  <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      wen_q     <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_out_q  <= pc_out_d;
      imm_q     <= imm_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      wen_q     <= wen_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
    end
  end

  // The request is masked while reset is held so no fetch is offered in the reset cycle.
  assign imem_req    = (state_q == S_REQ) & ~rst;
  assign imem_addr   = pc_q;
  assign id_valid    = (state_q == S_OUT);
  assign wen         = wen_q & id_valid;
  assign rd          = rd_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign immI        = imm_q;
  assign pc_o        = pc_out_q;
  assign halt        = halt_q;
  assign illegal     = illegal_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ifu_decode_stage.sv
// Bench for ifu_decode_stage: a memory/EX driver with random timing and a transaction-level
// model (fetch queue, pending instruction, expected PC) checked every negedge.
module tb_ifu_decode_stage;

  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] ADD    = 32'h0000_0033;

  logic        clk, rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid, id_ready, wen, halt, illegal;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] immI, pc_o;
  logic [1:0]  state_dbg;

  ifu_decode_stage #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready),
    .rd(rd), .rs1(rs1), .rs2(rs2), .wen(wen), .immI(immI), .pc_o(pc_o),
    .halt(halt), .illegal(illegal), .state_dbg_o(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  // model state
  logic [63:0] exp_q[$];     // fetch addresses accepted but not yet answered
  logic [31:0] prog[64];
  logic [63:0] exp_pc, cur_pc;
  logic [31:0] cur_inst;
  bit          pending, halted, illeg, cur_wen;
  bit          req_seen, id_seen, stale;
  int          out_cnt, rwait, dwait;
  int          rid, cyc, retires;
  int          rmin, rmax, vmin, vmax, dmin, dmax;
  bit          spur;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s run=%0d cyc=%0d got=%h expected=%h", name, rid, cyc, act, exp);
    end
  endtask

  function automatic bit is_addi(input logic [31:0] i);
    return (i[6:0] == 7'h13) && (i[14:12] == 3'd0);
  endfunction

  function automatic logic [5:0] idx(input logic [63:0] a);
    logic [63:0] d;
    d = (a - RST_PC) >> 2;
    return d[5:0];
  endfunction

  function automatic logic [63:0] sext12(input logic [31:0] i);
    logic signed [11:0] s;
    s = i[31:20];
    return 64'(s);
  endfunction

  // responses in OUT or HALT are a protocol violation the driver must never produce
  always @(posedge clk) begin
    if (!rst && imem_rvalid && (id_valid || halt)) begin
      failures++;
      $display("FAIL protocol: rvalid while id_valid=%0b halt=%0b", id_valid, halt);
    end
  end

  task automatic check_reset();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_wen", wen, 0);
    chk("rst_halt", halt, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_rd", rd, 0);
    chk("rst_rs1", rs1, 0);
    chk("rst_rs2", rs2, 0);
    chk("rst_immI", immI, 0);
    chk("rst_pc_o", pc_o, 0);
  endtask

  task automatic check();
    bit exp_req;
    exp_req = !halted && (exp_q.size() == 0) && !pending;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, exp_pc);
    chk("id_valid", id_valid, pending);
    chk("wen", wen, pending && cur_wen);
    chk("halt", halt, halted);
    chk("illegal", illegal, illeg);
    if (pending) begin
      chk("rd", rd, cur_inst[11:7]);
      chk("rs1", rs1, cur_inst[19:15]);
      chk("rs2", rs2, cur_inst[24:20]);
      chk("immI", immI, sext12(cur_inst));
      chk("pc_o", pc_o, cur_pc);
    end
    // hand-computed pins of the model
    if (rid == 1 && cyc == 0) begin
      chk("lit_first_req", imem_req, 1);
      chk("lit_first_addr", imem_addr, 64'h8000_0000);
    end
    if (rid == 1 && cyc == 2) begin
      chk("lit_addi_valid", id_valid, 1);
      chk("lit_addi_rd", rd, 5'd1);
      chk("lit_addi_rs1", rs1, 5'd0);
      chk("lit_addi_wen", wen, 1);
      chk("lit_addi_imm", immI, 64'd1);
      chk("lit_addi_pc", pc_o, 64'h8000_0000);
    end
    if (rid == 1 && cyc == 5) begin
      chk("lit_neg_valid", id_valid, 1);
      chk("lit_neg_rd", rd, 5'd0);
      chk("lit_neg_wen", wen, 0);
      chk("lit_neg_imm", immI, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    if (rid == 2 && imem_req && retires == 1) chk("lit_next_addr", imem_addr, 64'h8000_0004);
    if (rid == 61 && cyc == 0) begin
      chk("lit_refetch_req", imem_req, 1);
      chk("lit_refetch_addr", imem_addr, 64'h8000_0000);
    end
  endtask

  // driver + model update, once per negedge; transfers happen at the following posedge
  task automatic step();
    bit take_stale, deliver;
    check();
    deliver = 0;
    take_stale = stale;
    stale = 0;
    imem_ready = 0;
    imem_rvalid = 0;
    imem_rdata = $urandom;
    id_ready = 0;
    if (take_stale) begin
      imem_rvalid = 1;
      imem_rdata = ADD;
    end else if (exp_q.size() != 0) begin
      if (out_cnt <= 1) begin
        imem_rvalid = 1;
        imem_rdata = prog[idx(exp_q[0])];
        deliver = 1;
      end else out_cnt--;
    end
    if (imem_req && !take_stale) begin
      if (!req_seen) begin
        req_seen = 1;
        rwait = $urandom_range(rmax, rmin);
      end
      if (rwait == 0) imem_ready = 1;
      else rwait--;
      if (spur && exp_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        imem_rvalid = 1;
        imem_rdata = ADD;
      end
    end
    if (id_valid) begin
      if (!id_seen) begin
        id_seen = 1;
        dwait = $urandom_range(dmax, dmin);
      end
      if (dwait == 0) id_ready = 1;
      else dwait--;
    end else id_ready = ($urandom_range(0, 3) == 0);

    if (deliver) begin
      cur_pc = exp_q.pop_front();
      cur_inst = imem_rdata;
      if (is_addi(cur_inst)) begin
        pending = 1;
        cur_wen = (cur_inst[11:7] != 5'd0);
      end else begin
        halted = 1;
        if (cur_inst != EBRK) illeg = 1;
      end
    end
    if (imem_req && imem_ready) begin
      exp_q.push_back(exp_pc);
      out_cnt = $urandom_range(vmax, vmin);
      req_seen = 0;
    end
    if (id_valid && id_ready && pending) begin
      pending = 0;
      exp_pc = exp_pc + 64'd4;
      id_seen = 0;
      retires++;
    end
  endtask

  task automatic do_reset(input bit with_stale);
    rst = 1;
    imem_ready = 0;
    imem_rvalid = 0;
    imem_rdata = '0;
    id_ready = 0;
    repeat (3) begin
      @(negedge clk);
      check_reset();
    end
    @(negedge clk);
    rst = 0;
    exp_q.delete();
    exp_pc = RST_PC;
    pending = 0; halted = 0; illeg = 0; cur_wen = 0;
    req_seen = 0; id_seen = 0; retires = 0;
    stale = with_stale;
    #1;
  endtask

  task automatic set_prog(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    for (int i = 0; i < 64; i++) prog[i] = EBRK;
    prog[0] = a;
    prog[1] = b;
    prog[2] = c;
  endtask

  task automatic gen_prog();
    int n;
    logic [4:0] r;
    for (int i = 0; i < 64; i++) prog[i] = EBRK;
    n = $urandom_range(1, 12);
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      prog[i] = {12'($urandom), 5'($urandom), 3'b000, r, 7'b0010011};
    end
    case ($urandom_range(0, 2))
      0: prog[n] = EBRK;
      1: prog[n] = ADD;
      default: prog[n] = $urandom;
    endcase
  endtask

  task automatic run(input int id, input int a, input int b, input int c, input int d,
                     input int e, input int f, input bit sp);
    int post;
    rid = id; rmin = a; rmax = b; vmin = c; vmax = d; dmin = e; dmax = f; spur = sp;
    post = 0;
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) @(negedge clk);
      cyc = k;
      step();
      if (id == 6 && k == 3) return;
      if (halted) begin
        post++;
        if (post > 6) return;
      end
    end
    chk("run_done", halted, 1);
  endtask

  initial begin
    rid = 0; cyc = 0;
    do_reset(0);
    set_prog(32'h0010_0093, 32'hFFF0_0013, EBRK);
    run(1, 0, 0, 1, 1, 0, 0, 0);
    chk("end1_halt", halt, 1);
    chk("end1_illegal", illegal, 0);

    do_reset(0);
    set_prog(32'h0010_0093, 32'h0020_8113, EBRK);
    run(2, 4, 4, 2, 2, 3, 3, 0);

    for (int k = 0; k < 10; k++) begin
      do_reset(0);
      gen_prog();
      run(3, 0, 3, 1, 4, 0, 3, 1);
    end

    do_reset(0);
    set_prog(EBRK, EBRK, EBRK);
    run(4, 0, 2, 1, 3, 0, 0, 1);
    chk("end4_halt", halt, 1);
    chk("end4_illegal", illegal, 0);

    do_reset(0);
    set_prog(ADD, EBRK, EBRK);
    run(5, 0, 2, 1, 3, 0, 0, 1);
    chk("end5_halt", halt, 1);
    chk("end5_illegal", illegal, 1);

    do_reset(0);
    set_prog(32'h0010_0093, EBRK, EBRK);
    run(6, 0, 0, 6, 6, 0, 0, 0);
    do_reset(1);
    run(61, 0, 0, 1, 1, 0, 0, 0);
    chk("end61_halt", halt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
